rx_sample_ring_buffer: RTL and testbench

// - Parametrised circular buffer of filtered RX samples; next generation of the fixed 16x512 sample BRAM.
// - Writes auto-increment a wrap-around pointer. Reads are addressed relative to the newest sample.
// - Tracks fill level, supports freeze (snapshot) and flags out-of-range reads.
// - Sits between the RX filter output and the correlator/detection stage.

---
 rtl/rx_sample_ring_buffer.sv | 135 +++++++++++++
 tb/tb_rx_sample_ring_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_sample_ring_buffer
// Description : Circular buffer of filtered RX samples. Writes auto-increment
//               a wrap-around pointer; reads are addressed relative to the
//               newest stored sample. Tracks fill level, supports freeze and
//               flags reads that reach past the oldest stored sample.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sample_ring_buffer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter int RD_PIPE = 1
) (
  input  logic              clk,
  input  logic              rx_rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              freeze,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              full
);

  localparam int              c_DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(c_DEPTH);

  logic [DATA_W-1:0] r_ram [c_DEPTH];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_fill_cnt;
  logic              r_full;

  logic              r_s1_valid;
  logic              r_s1_err;
  logic [DATA_W-1:0] r_s1_data;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_rd_err;
  logic              w_out_valid;
  logic              w_out_err;
  logic [DATA_W-1:0] w_out_data;

  // Freeze drops strobes outright; nothing is queued for later.
  assign w_wr_en  = wr_valid & ~freeze;
  // Address and range check use the pre-write pointer/fill of this cycle.
  assign w_raddr  = r_wr_ptr - ADDR_W'(1) - rd_offset;
  assign w_rd_err = ({1'b0, rd_offset} >= r_fill_cnt);

  // Sample storage; never cleared by reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rx_rst) begin
      r_ram[r_wr_ptr] <= wr_data;
    end
  end

  // Write pointer wraps silently; fill level saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_full     <= 1'b0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (!r_full) begin
        r_fill_cnt <= r_fill_cnt + (ADDR_W + 1)'(1);
        r_full     <= (r_fill_cnt == c_DEPTH_CNT - (ADDR_W + 1)'(1));
      end
    end
  end

  // First read stage: RAM read (read-first on collision) with error masking;
  // the data register only moves on a request so the output holds otherwise.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= rd_req;
      r_s1_err   <= rd_req & w_rd_err;
      if (rd_req) begin
        r_s1_data <= w_rd_err ? '0 : r_ram[w_raddr];
      end
    end
  end

  generate
    if (RD_PIPE == 2) begin : g_pipe2
      logic              r_s2_valid;
      logic              r_s2_err;
      logic [DATA_W-1:0] r_s2_data;

      // Optional output register stage for timing closure.
      always_ff @(posedge clk) begin
        if (rx_rst) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign w_out_valid = r_s2_valid;
      assign w_out_err   = r_s2_err;
      assign w_out_data  = r_s2_data;
    end else begin : g_pipe1
      assign w_out_valid = r_s1_valid;
      assign w_out_err   = r_s1_err;
      assign w_out_data  = r_s1_data;
    end
  endgenerate

  // A response still in flight when reset arrives is suppressed immediately.
  assign rd_valid = w_out_valid & ~rx_rst;
  assign rd_err   = w_out_err & ~rx_rst;
  assign rd_data  = w_out_data;

  assign wr_ptr   = r_wr_ptr;
  assign fill_cnt = r_fill_cnt;
  assign full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_rx_sample_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_sample_ring_buffer
// Description : Self-checking bench for rx_sample_ring_buffer, one instance
//               per legal read latency driven from the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_sample_ring_buffer;

  localparam int c_DW    = 16;
  localparam int c_AW    = 9;
  localparam int c_DEPTH = 512;

  logic            clk = 1'b0;
  logic            rx_rst = 1'b1;
  logic            wr_valid = 1'b0;
  logic [c_DW-1:0] wr_data = '0;
  logic            freeze = 1'b0;
  logic            rd_req = 1'b0;
  logic [c_AW-1:0] rd_offset = '0;

  logic            rd_valid1, rd_err1, full1;
  logic [c_DW-1:0] rd_data1;
  logic [c_AW-1:0] wr_ptr1;
  logic [c_AW:0]   fill_cnt1;
  logic            rd_valid2, rd_err2, full2;
  logic [c_DW-1:0] rd_data2;
  logic [c_AW-1:0] wr_ptr2;
  logic [c_AW:0]   fill_cnt2;

  rx_sample_ring_buffer #(.DATA_W(c_DW), .ADDR_W(c_AW), .RD_PIPE(1)) u_dut1 (
    .clk(clk), .rx_rst(rx_rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .freeze(freeze), .rd_req(rd_req), .rd_offset(rd_offset),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_err(rd_err1),
    .wr_ptr(wr_ptr1), .fill_cnt(fill_cnt1), .full(full1)
  );

  rx_sample_ring_buffer #(.DATA_W(c_DW), .ADDR_W(c_AW), .RD_PIPE(2)) u_dut2 (
    .clk(clk), .rx_rst(rx_rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .freeze(freeze), .rd_req(rd_req), .rd_offset(rd_offset),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_err(rd_err2),
    .wr_ptr(wr_ptr2), .fill_cnt(fill_cnt2), .full(full2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic            err;
    logic [c_DW-1:0] data;
  } exp_t;

  typedef struct {
    bit              rst;
    bit              wv;
    logic [c_DW-1:0] wd;
    bit              fz;
    bit              rq;
    logic [c_AW-1:0] ro;
    logic [c_DW-1:0] xd;
    bit              xe;
    logic [c_AW-1:0] xp;
    logic [c_AW:0]   xf;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic [c_DW-1:0] mm [c_DEPTH];
  logic [c_AW-1:0] m_wp   = '0;
  logic [c_AW:0]   m_fill = '0;
  logic [c_DW-1:0] last1  = '0;
  logic [c_DW-1:0] last2  = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response checker for both latencies.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (rd_valid1 === 1'b1) begin
        if (q1.size() == 0) chk("p1 unexpected rd_valid", 1, 0);
        else begin
          e = q1.pop_front();
          chk("p1 latency", cyc, e.due);
          chk("p1 rd_data", {16'h0, rd_data1}, {16'h0, e.data});
          chk("p1 rd_err", {31'h0, rd_err1}, {31'h0, e.err});
        end
        last1 = rd_data1;
      end else begin
        chk("p1 rd_err idle", {31'h0, rd_err1}, 0);
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          chk("p1 missing rd_valid", 0, 1);
          void'(q1.pop_front());
        end
        if (!rx_rst) chk("p1 rd_data hold", {16'h0, rd_data1}, {16'h0, last1});
      end
      if (rd_valid2 === 1'b1) begin
        if (q2.size() == 0) chk("p2 unexpected rd_valid", 1, 0);
        else begin
          e = q2.pop_front();
          chk("p2 latency", cyc, e.due);
          chk("p2 rd_data", {16'h0, rd_data2}, {16'h0, e.data});
          chk("p2 rd_err", {31'h0, rd_err2}, {31'h0, e.err});
        end
        last2 = rd_data2;
      end else begin
        chk("p2 rd_err idle", {31'h0, rd_err2}, 0);
        if (q2.size() > 0 && q2[0].due <= cyc) begin
          chk("p2 missing rd_valid", 0, 1);
          void'(q2.pop_front());
        end
        if (!rx_rst) chk("p2 rd_data hold", {16'h0, rd_data2}, {16'h0, last2});
      end
    end
  end

  // One clock of stimulus; read expectations come from the reference model
  // unless use_exp supplies them, and status is checked after the edge.
  task automatic drive(input bit rst, input bit wv, input logic [c_DW-1:0] wd,
                       input bit fz, input bit rq, input logic [c_AW-1:0] ro,
                       input bit use_exp, input logic [c_DW-1:0] xd, input bit xe);
    exp_t e;
    logic [c_AW-1:0] a;
    rx_rst    = rst;
    wr_valid  = wv;
    wr_data   = wd;
    freeze    = fz;
    rd_req    = rq;
    rd_offset = ro;
    if (rst) begin
      q1.delete();
      q2.delete();
    end else if (rq) begin
      if (use_exp) begin
        e.err  = xe;
        e.data = xd;
      end else begin
        a      = m_wp - 9'd1 - ro;
        e.err  = ({1'b0, ro} >= m_fill);
        e.data = e.err ? '0 : mm[a];
      end
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_wp   = '0;
      m_fill = '0;
      last1  = '0;
      last2  = '0;
    end else if (wv && !fz) begin
      mm[m_wp] = wd;
      m_wp     = m_wp + 9'd1;
      if (m_fill < 10'(c_DEPTH)) m_fill = m_fill + 10'd1;
    end
    chk("p1 wr_ptr", {23'h0, wr_ptr1}, {23'h0, m_wp});
    chk("p1 fill_cnt", {22'h0, fill_cnt1}, {22'h0, m_fill});
    chk("p1 full", {31'h0, full1}, {31'h0, (m_fill == 10'(c_DEPTH))});
    chk("p2 wr_ptr", {23'h0, wr_ptr2}, {23'h0, m_wp});
    chk("p2 fill_cnt", {22'h0, fill_cnt2}, {22'h0, m_fill});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 0, 0, 9'd0, 0, 16'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    tbl[0]  = '{1, 0, 16'h0,    0, 0, 9'd0, 16'h0,    0, 9'd0, 10'd0};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{0, 1, 16'(i), 0, 0, 9'd0, 16'h0, 0, 9'(i), 10'(i)};
    tbl[6]  = '{0, 0, 16'h0,    0, 1, 9'd0, 16'd5,    0, 9'd5, 10'd5};
    tbl[7]  = '{0, 0, 16'h0,    0, 1, 9'd4, 16'd1,    0, 9'd5, 10'd5};
    tbl[8]  = '{0, 0, 16'h0,    0, 1, 9'd5, 16'd0,    1, 9'd5, 10'd5};
    tbl[9]  = '{0, 1, 16'h1234, 0, 0, 9'd0, 16'h0,    0, 9'd6, 10'd6};
    tbl[10] = '{0, 1, 16'hAAAA, 0, 1, 9'd0, 16'h1234, 0, 9'd7, 10'd7};
    tbl[11] = '{0, 0, 16'h0,    0, 1, 9'd0, 16'hAAAA, 0, 9'd7, 10'd7};
    tbl[12] = '{0, 0, 16'h0,    0, 1, 9'd0, 16'hAAAA, 0, 9'd7, 10'd7};
    tbl[13] = '{1, 0, 16'h0,    0, 0, 9'd0, 16'h0,    0, 9'd0, 10'd0};
    tbl[14] = '{0, 0, 16'h0,    0, 1, 9'd0, 16'h0,    1, 9'd0, 10'd0};
    tbl[15] = '{0, 0, 16'h0,    0, 0, 9'd0, 16'h0,    0, 9'd0, 10'd0};

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Basic write/read, same-cycle write visibility, reset with read in flight.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].fz, tbl[i].rq, tbl[i].ro,
            1, tbl[i].xd, tbl[i].xe);
      chk("tbl wr_ptr", {23'h0, wr_ptr1}, {23'h0, tbl[i].xp});
      chk("tbl fill_cnt", {22'h0, fill_cnt1}, {22'h0, tbl[i].xf});
    end
    idle(3);

    // Wrap past DEPTH: oldest surviving sample is index 3.
    for (int i = 0; i < c_DEPTH + 3; i++) drive(0, 1, 16'(i), 0, 0, 9'd0, 0, 16'h0, 0);
    chk("wrap full", {31'h0, full1}, 1);
    chk("wrap fill_cnt", {22'h0, fill_cnt1}, 512);
    chk("wrap wr_ptr", {23'h0, wr_ptr1}, 3);
    drive(0, 0, 16'h0, 0, 1, 9'd511, 1, 16'd3, 0);
    // Collision: the oldest entry is being overwritten in the same cycle.
    drive(0, 1, 16'hBEEF, 0, 1, 9'd511, 1, 16'd3, 0);
    drive(0, 0, 16'h0, 0, 1, 9'd0, 1, 16'hBEEF, 0);
    drive(0, 0, 16'h0, 0, 1, 9'd511, 1, 16'd4, 0);
    idle(3);

    // Freeze drops writes while reads keep working.
    drive(0, 0, 16'h0, 0, 1, 9'd0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0, 1, 9'd1, 0, 16'h0, 0);
    for (int i = 0; i < 10; i++)
      drive(0, 1, 16'($urandom), 1, 1, 9'(i % 2), 1, (i % 2 == 0) ? 16'hBEEF : 16'd514, 0);
    chk("freeze wr_ptr", {23'h0, wr_ptr1}, 4);
    chk("freeze fill_cnt", {22'h0, fill_cnt1}, 512);
    idle(3);

    // Back-to-back requests: the RD_PIPE=2 instance answers 2 cycles later, in order.
    for (int i = 0; i < 4; i++) drive(0, 0, 16'h0, 0, 1, 9'(i), 0, 16'h0, 0);
    idle(4);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, 16'($urandom),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
            9'($urandom_range(0, int'(m_fill) + 2)), 0, 16'h0, 0);
    end
    idle(4);

    chk("p1 queue drained", q1.size(), 0);
    chk("p2 queue drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
